clk_div_monitor: RTL

- Checks a divided clock produced by the odd/even clock dividers, such as the 50%-duty odd divider whose output is an OR of a posedge and a negedge flop.
- Samples that clock in the source-clock domain and measures its period and high time in source-clock cycles.
- Declares lock after N consecutive in-tolerance periods, and flags period errors and a stopped clock.
- Sits directly downstream of the divider, used by bring-up logic and the clock-health status register.

---
 rtl/clk_div_monitor.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/clk_div_monitor.sv
// clk_div_monitor: measures period and high time of a divided clock
// in clk_in cycles; tracks lock, period errors and a stopped clock.
module clk_div_monitor #(
  parameter int CNT_W      = 8,
  parameter int EXP_PERIOD = 5,
  parameter int TOL        = 0,
  parameter int LOCK_N     = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic             div_clk,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_cnt,
  output logic             meas_valid,
  output logic             locked,
  output logic             period_err,
  output logic             timeout
);

  localparam int LO_I = (EXP_PERIOD > TOL) ? EXP_PERIOD - TOL : 0;
  localparam int HI_I = EXP_PERIOD + TOL;

  localparam logic [CNT_W-1:0] LO_B    = CNT_W'(LO_I);
  localparam logic [CNT_W-1:0] HI_B    = CNT_W'(HI_I);
  localparam logic [CNT_W-1:0] TO_TC   = CNT_W'(TIMEOUT - 2);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_0   = '0;
  localparam logic [3:0]       LOCK_C  = 4'(LOCK_N);

  typedef enum logic [1:0] {
    IDLE,
    MEAS,
    LOCK
  } state_t;

  state_t state_q;

  logic s1_q, s2_q, s3_q;
  logic rise, hi;

  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [3:0]       cons_q, cons_d;
  logic             in_tol;

  logic [CNT_W-1:0] period_q, high_q;
  logic             mvalid_q, locked_q, perr_q, tout_q;

  assign rise = s2_q & ~s3_q;
  assign hi   = s2_q;

  // two-flop synchroniser plus edge register for div_clk
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= div_clk;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // saturating increments; at a rise these are the measured values
  always_comb begin
    pcnt_d = pcnt_q;
    hcnt_d = hcnt_q;
    cons_d = cons_q;
    if (pcnt_q != CNT_MAX) pcnt_d = pcnt_q + CNT_ONE;
    if (hcnt_q != CNT_MAX && hi) hcnt_d = hcnt_q + CNT_ONE;
    if (cons_q >= LOCK_C) cons_d = LOCK_C;
    else cons_d = cons_q + 4'd1;
    in_tol = (pcnt_d >= LO_B) && (pcnt_d <= HI_B);
  end

  // measurement FSM with registered outputs
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pcnt_q   <= CNT_0;
      hcnt_q   <= CNT_0;
      cons_q   <= 4'd0;
      period_q <= CNT_0;
      high_q   <= CNT_0;
      mvalid_q <= 1'b0;
      locked_q <= 1'b0;
      perr_q   <= 1'b0;
      tout_q   <= 1'b0;
    end else begin
      mvalid_q <= 1'b0;
      perr_q   <= 1'b0;
      if (!en) begin
        state_q  <= IDLE;
        pcnt_q   <= CNT_0;
        hcnt_q   <= CNT_0;
        cons_q   <= 4'd0;
        locked_q <= 1'b0;
        tout_q   <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            pcnt_q <= CNT_0;
            hcnt_q <= CNT_0;
            if (rise) begin
              state_q <= MEAS;
              tout_q  <= 1'b0;
            end
          end
          MEAS, LOCK: begin
            if (rise) begin
              period_q <= pcnt_d;
              high_q   <= hcnt_d;
              mvalid_q <= 1'b1;
              pcnt_q   <= CNT_0;
              hcnt_q   <= CNT_0;
              if (in_tol) begin
                cons_q <= cons_d;
                if (cons_d == LOCK_C) begin
                  locked_q <= 1'b1;
                  state_q  <= LOCK;
                end
              end else begin
                perr_q   <= 1'b1;
                cons_q   <= 4'd0;
                locked_q <= 1'b0;
                state_q  <= MEAS;
              end
            end else if (pcnt_q == TO_TC) begin
              tout_q   <= 1'b1;
              locked_q <= 1'b0;
              cons_q   <= 4'd0;
              pcnt_q   <= CNT_0;
              hcnt_q   <= CNT_0;
              state_q  <= IDLE;
            end else begin
              pcnt_q <= pcnt_d;
              hcnt_q <= hcnt_d;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign period     = period_q;
  assign high_cnt   = high_q;
  assign meas_valid = mvalid_q;
  assign locked     = locked_q;
  assign period_err = perr_q;
  assign timeout    = tout_q;

endmodule
